// File: rtl/taxi_axis_frame_gen_if.sv
// AXI4-Stream interface carrying the stream widths as parameters.
// Sources drive everything except tready; sinks drive only tready.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter int LAST_EN = 1,
    parameter int ID_EN   = 0,
    parameter int ID_W    = 8,
    parameter int DEST_W  = 8,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport src (
        output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/taxi_axis_frame_gen.sv
// AXI4-Stream frame generator: each accepted (len, seed, id) command becomes one frame
// whose payload bytes count up from seed.
module taxi_axis_frame_gen #(
    parameter int LEN_W    = 16,
    parameter int CMD_ID_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [7:0]          cmd_seed,
    input  logic [CMD_ID_W-1:0] cmd_id,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    taxi_axis_if.src            m_axis,
    output logic                busy,
    output logic                zero_len,
    output logic [31:0]         frame_cnt
);
    localparam int DATA_W  = m_axis.DATA_W;
    localparam int KEEP_W  = m_axis.KEEP_W;
    localparam int LAST_EN = m_axis.LAST_EN;
    localparam int ID_EN   = m_axis.ID_EN;
    localparam int ID_W    = m_axis.ID_W;

    if (DATA_W != 8 * KEEP_W) begin : g_bad_data_w
        $fatal(1, "taxi_axis_frame_gen: DATA_W must equal 8*KEEP_W");
    end
    if (CMD_ID_W != ID_W) begin : g_bad_id_w
        $fatal(1, "taxi_axis_frame_gen: CMD_ID_W must equal the stream ID_W");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [7:0]          base_q, base_d;
    logic [CMD_ID_W-1:0] id_q, id_d;
    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic                last_q, last_d;
    logic                zero_len_q, zero_len_d;
    logic [31:0]         frame_cnt_q, frame_cnt_d;

    logic                accept, xfer, load;
    logic [LEN_W-1:0]    beat_rem;
    logic [7:0]          beat_base;
    logic [DATA_W-1:0]   beat_data;
    logic [KEEP_W-1:0]   beat_keep;
    logic                beat_last;

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign xfer      = tvalid_q && m_axis.tready;

    // The beat being built comes from the command while idle, from the saved cursor otherwise.
    always_comb begin
        beat_rem  = (state_q == StIdle) ? cmd_len : rem_q;
        beat_base = (state_q == StIdle) ? cmd_seed : base_q;
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (int'(beat_rem) > i) begin
                beat_keep[i]         = 1'b1;
                beat_data[8*i +: 8] = beat_base + 8'(i);
            end
        end
        beat_last = int'(beat_rem) <= KEEP_W;
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        base_d      = base_q;
        id_d        = id_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        last_d      = last_q;
        zero_len_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        zero_len_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        id_d    = cmd_id;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d     = StIdle;
                        tvalid_d    = 1'b0;
                        tdata_d     = '0;
                        tkeep_d     = '0;
                        last_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 32'd1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = beat_data;
            tkeep_d  = beat_keep;
            last_d   = beat_last;
            rem_d    = beat_last ? '0 : beat_rem - LEN_W'(KEEP_W);
            base_d   = beat_base + 8'(KEEP_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            base_q      <= '0;
            id_q        <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            last_q      <= 1'b0;
            zero_len_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            base_q      <= base_d;
            id_q        <= id_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            last_q      <= last_d;
            zero_len_q  <= zero_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tstrb  = tkeep_q;
    assign m_axis.tlast  = (LAST_EN != 0) ? last_q : 1'b0;
    assign m_axis.tid    = (ID_EN != 0) ? id_q : '0;
    assign m_axis.tdest  = '0;
    assign m_axis.tuser  = '0;

    assign busy      = (state_q == StSend);
    assign zero_len  = zero_len_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_taxi_axis_frame_gen.sv
// Directed bench for taxi_axis_frame_gen: one 8-bit and one 32-bit instance
// sharing clock and reset.
module tb_taxi_axis_frame_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cmd_len8, cmd_len32;
    logic [7:0]  cmd_seed8, cmd_seed32;
    logic [7:0]  cmd_id8;
    logic [3:0]  cmd_id32;
    logic        cmd_valid8, cmd_valid32;
    logic        cmd_ready8, cmd_ready32;
    logic        busy8, busy32;
    logic        zero_len8, zero_len32;
    logic [31:0] frame_cnt8, frame_cnt32;
    logic        tready8, tready32;

    taxi_axis_if #(.DATA_W(8), .KEEP_W(1), .LAST_EN(1), .ID_EN(0), .ID_W(8),
                   .DEST_W(8), .USER_W(1)) ax8 ();
    taxi_axis_if #(.DATA_W(32), .KEEP_W(4), .LAST_EN(1), .ID_EN(1), .ID_W(4),
                   .DEST_W(8), .USER_W(1)) ax32 ();

    assign ax8.tready  = tready8;
    assign ax32.tready = tready32;

    taxi_axis_frame_gen #(.LEN_W(16), .CMD_ID_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .cmd_len   (cmd_len8),
        .cmd_seed  (cmd_seed8),
        .cmd_id    (cmd_id8),
        .cmd_valid (cmd_valid8),
        .cmd_ready (cmd_ready8),
        .m_axis    (ax8),
        .busy      (busy8),
        .zero_len  (zero_len8),
        .frame_cnt (frame_cnt8)
    );

    taxi_axis_frame_gen #(.LEN_W(16), .CMD_ID_W(4)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .cmd_len   (cmd_len32),
        .cmd_seed  (cmd_seed32),
        .cmd_id    (cmd_id32),
        .cmd_valid (cmd_valid32),
        .cmd_ready (cmd_ready32),
        .m_axis    (ax32),
        .busy      (busy32),
        .zero_len  (zero_len32),
        .frame_cnt (frame_cnt32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat32(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx;
        logic        stalled;
        logic [31:0] held;

        cmd_len8 = '0; cmd_seed8 = '0; cmd_id8 = '0; cmd_valid8 = 1'b0;
        cmd_len32 = '0; cmd_seed32 = '0; cmd_id32 = '0; cmd_valid32 = 1'b0;
        tready8 = 1'b1; tready32 = 1'b1;

        // Reset state
        #1;
        check("rst_cmd_ready", cmd_ready32, 0);
        check("rst_tvalid", ax32.tvalid, 0);
        check("rst_tdata", ax32.tdata, 0);
        check("rst_tkeep", ax32.tkeep, 0);
        check("rst_tlast", ax32.tlast, 0);
        check("rst_busy", busy32, 0);
        check("rst_zero_len", zero_len32, 0);
        check("rst_frame_cnt", frame_cnt32, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready32, 1);

        // 1: 8-bit, len 4, seed 0x10
        cmd_len8 = 16'd4; cmd_seed8 = 8'h10; cmd_valid8 = 1'b1;
        tick();
        cmd_valid8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_tvalid", ax8.tvalid, 1);
            check("t1_tdata", ax8.tdata, 8'h10 + k);
            check("t1_tlast", ax8.tlast, (k == 3));
            check("t1_busy", busy8, 1);
            tick();
        end
        check("t1_tvalid_end", ax8.tvalid, 0);
        check("t1_busy_end", busy8, 0);
        check("t1_frame_cnt", frame_cnt8, 1);

        // 2: 32-bit, len 6, seed 0xFE
        cmd_len32 = 16'd6; cmd_seed32 = 8'hFE; cmd_id32 = 4'd5; cmd_valid32 = 1'b1;
        tick();
        cmd_valid32 = 1'b0;
        check("t2_b0_tdata", ax32.tdata, 32'h0100FFFE);
        check("t2_b0_tkeep", ax32.tkeep, 4'hF);
        check("t2_b0_tstrb", ax32.tstrb, 4'hF);
        check("t2_b0_tlast", ax32.tlast, 0);
        check("t2_b0_tid", ax32.tid, 5);
        tick();
        check("t2_b1_tdata", ax32.tdata, 32'h00000302);
        check("t2_b1_tkeep", ax32.tkeep, 4'h3);
        check("t2_b1_tlast", ax32.tlast, 1);
        tick();
        check("t2_tvalid_end", ax32.tvalid, 0);
        check("t2_frame_cnt", frame_cnt32, 1);

        // 3: 32-bit, len 16, tready alternating 1,0,1,0,...
        cmd_len32 = 16'd16; cmd_seed32 = 8'h20; cmd_valid32 = 1'b1;
        tick();
        cmd_valid32 = 1'b0;
        idx = 0;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            tready32 = (c % 2 == 0);
            if (stalled) begin
                check("t3_stall_tvalid", ax32.tvalid, 1);
                check("t3_stall_tdata", ax32.tdata, held);
            end
            if (ax32.tvalid) begin
                if (tready32) begin
                    check("t3_tdata", ax32.tdata, pat32(8'h20 + 8'(4 * idx)));
                    check("t3_tkeep", ax32.tkeep, 4'hF);
                    check("t3_tlast", ax32.tlast, (idx == 3));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held = ax32.tdata;
                    stalled = 1'b1;
                end
            end
            tick();
        end
        tready32 = 1'b1;
        check("t3_beats", idx, 4);
        check("t3_tvalid_end", ax32.tvalid, 0);
        check("t3_frame_cnt", frame_cnt32, 2);

        // 4: zero-length command
        cmd_len32 = 16'd0; cmd_seed32 = 8'h77; cmd_valid32 = 1'b1;
        check("t4_cmd_ready", cmd_ready32, 1);
        tick();
        cmd_valid32 = 1'b0;
        check("t4_zero_len", zero_len32, 1);
        check("t4_tvalid", ax32.tvalid, 0);
        check("t4_busy", busy32, 0);
        tick();
        check("t4_zero_len_drop", zero_len32, 0);
        check("t4_tvalid2", ax32.tvalid, 0);
        check("t4_frame_cnt", frame_cnt32, 2);

        // 6: cmd_valid held, two back-to-back len 3 frames on the 8-bit instance
        cmd_len8 = 16'd3; cmd_seed8 = 8'h30; cmd_valid8 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check("t6_tvalid", ax8.tvalid, (c != 4 && c != 8));
            if (c != 4 && c != 8) begin
                check("t6_tdata", ax8.tdata, (c < 4) ? 8'h30 + c - 1 : 8'h50 + c - 5);
                check("t6_tlast", ax8.tlast, (c == 3 || c == 7));
            end
            if (c == 4) begin
                check("t6_cmd_ready_gap", cmd_ready8, 1);
                cmd_seed8 = 8'h50;
            end
            if (c == 5) cmd_valid8 = 1'b0;
            tick();
        end
        check("t6_tvalid_end", ax8.tvalid, 0);
        check("t6_frame_cnt", frame_cnt8, 3);

        // 5: reset after 2 of 8 beats, then a fresh len 8 frame
        cmd_len8 = 16'd8; cmd_seed8 = 8'h40; cmd_valid8 = 1'b1;
        tick();
        cmd_valid8 = 1'b0;
        tick();
        tick();
        check("t5_pre_rst_tdata", ax8.tdata, 8'h42);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_tvalid", ax8.tvalid, 0);
        check("t5_rst_busy", busy8, 0);
        check("t5_rst_cmd_ready", cmd_ready8, 0);
        check("t5_rst_frame_cnt8", frame_cnt8, 0);
        check("t5_rst_frame_cnt32", frame_cnt32, 0);
        tick();
        rst = 1'b0;
        cmd_len8 = 16'd8; cmd_seed8 = 8'h80; cmd_valid8 = 1'b1;
        tick();
        cmd_valid8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t5_tvalid", ax8.tvalid, 1);
            check("t5_tdata", ax8.tdata, 8'h80 + k);
            check("t5_tlast", ax8.tlast, (k == 7));
            tick();
        end
        check("t5_tvalid_end", ax8.tvalid, 0);
        check("t5_frame_cnt", frame_cnt8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
